// File: rtl/interrupt_ack_sequencer.sv
// 8259-style priority resolver, in-service register and 8086-mode INTA sequencer.
// Resolves the highest eligible request, runs the two-pulse acknowledge and executes EOI/rotation.
module interrupt_ack_sequencer #(
  parameter int VECTOR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              interrupt_req_register,
  input  logic [7:0]              interrupt_mask,
  input  logic                    inta_n,
  input  logic [VECTOR_WIDTH-1:0] vector_base,
  input  logic                    auto_eoi,
  input  logic                    rotate_on_aeoi,
  input  logic                    eoi_req,
  input  logic                    eoi_specific,
  input  logic                    eoi_rotate,
  input  logic [2:0]              eoi_level,
  output logic                    int_out,
  output logic                    freeze,
  output logic [7:0]              clear_interrupt_req,
  output logic [7:0]              in_service_register,
  output logic [2:0]              lowest_priority,
  output logic [7:0]              data_out,
  output logic                    data_out_en
);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t     state;
  logic       inta_q;
  logic [2:0] sel;
  logic       spurious;

  logic       fall, rise, eligible, idle_next, aeoi_done, eoi_hit;
  logic [3:0] pend_top, isr_top;
  logic [2:0] pend_lvl, isr_lvl, eoi_lvl;
  logic [7:0] isr_set, isr_clr;

  // Rotates v so the highest-priority level lands at bit 0, then returns {found, rank}.
  function automatic logic [3:0] top_rank(input logic [7:0] v, input logic [2:0] lp);
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  start;
    logic [3:0]  res;
    dbl   = {v, v};
    start = lp + 3'd1;
    rot   = dbl[start +: 8];
    res   = 4'd0;
    for (int k = 7; k >= 0; k--)
      if (rot[k]) res = {1'b1, 3'(k)};
    return res;
  endfunction

  always_comb begin
    fall      = inta_q & ~inta_n;
    rise      = ~inta_q & inta_n;
    pend_top  = top_rank(interrupt_req_register & ~interrupt_mask, lowest_priority);
    isr_top   = top_rank(in_service_register, lowest_priority);
    pend_lvl  = pend_top[2:0] + lowest_priority + 3'd1;
    isr_lvl   = isr_top[2:0] + lowest_priority + 3'd1;
    // Fully nested: a request must outrank every level already in service.
    eligible  = pend_top[3] && (!isr_top[3] || (pend_top[2:0] < isr_top[2:0]));
    eoi_hit   = eoi_req && (eoi_specific || isr_top[3]);
    eoi_lvl   = eoi_specific ? eoi_level : isr_lvl;
    idle_next = ((state == IDLE) && !fall) || ((state == ACK2) && rise);
    aeoi_done = (state == ACK2) && rise && auto_eoi && !spurious;
    isr_set   = ((state == IDLE) && fall && eligible) ? (8'd1 << pend_lvl) : 8'd0;
    isr_clr   = (eoi_hit ? (8'd1 << eoi_lvl) : 8'd0) | (aeoi_done ? (8'd1 << sel) : 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      inta_q              <= 1'b1;
      sel                 <= 3'd7;
      spurious            <= 1'b0;
      int_out             <= 1'b0;
      freeze              <= 1'b0;
      clear_interrupt_req <= 8'd0;
      in_service_register <= 8'd0;
      lowest_priority     <= 3'd7;
      data_out            <= 8'd0;
      data_out_en         <= 1'b0;
    end else begin
      inta_q              <= inta_n;
      int_out             <= idle_next && eligible;
      freeze              <= !idle_next;
      clear_interrupt_req <= isr_set;
      // Set is OR-ed after the clears so an ACK1 set beats a same-cycle EOI on that bit.
      in_service_register <= (in_service_register & ~isr_clr) | isr_set;
      if (eoi_hit && eoi_rotate)
        lowest_priority <= eoi_lvl;
      else if (aeoi_done && rotate_on_aeoi)
        lowest_priority <= sel;
      case (state)
        IDLE: if (fall) begin
          state <= ACK1;
          if (eligible) begin
            sel      <= pend_lvl;
            spurious <= 1'b0;
          end else begin
            sel      <= 3'd7;
            spurious <= 1'b1;
          end
        end
        ACK1: if (rise) state <= WAIT2;
        WAIT2: if (fall) begin
          state       <= ACK2;
          data_out    <= 8'({vector_base, sel});
          data_out_en <= 1'b1;
        end
        ACK2: if (rise) begin
          state       <= IDLE;
          data_out_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
